sb_spram256ka: RTL and testbench
================================

// Module: sb_spram256ka
// PURPOSE
//  Behavioural model of the iCE40UP 256-kbit single-port SRAM: 16384 x 16 bit, nibble write masks.
//  Two instances form one 64 KiB, 32-bit SoC RAM bank behind the picorv32 bus.
//  Instance hi carries bits 31:16; instance lo carries bits 15:0.
//  Synchronous read with one-cycle latency; models standby, sleep and power-off modes.
// PARAMETERS
//  ADDR_W  14     word address width; depth = 2**ADDR_W = 16384
//  DATA_W  16     data width; fixed at 16 because MASKWREN is 4 nibble enables
// PORTS
//  CLOCK       in   1   single clock, rising-edge
//  RESET       in   1   asynchronous, active-high; clears DATAOUT register only
//  ADDRESS     in   14  word address
//  DATAIN      in   16  write data
//  MASKWREN    in   4   nibble write enables; bit i covers DATAIN[4i+3:4i]
//  WREN        in   1   1 = write, 0 = read
//  CHIPSELECT  in   1   access enable
//  STANDBY     in   1   1 = no access, contents and DATAOUT retained
//  SLEEP       in   1   1 = no access, DATAOUT forced 0, contents retained
//  POWEROFF    in   1   active-LOW: 0 = powered off, contents lost
//  DATAOUT     out  16  registered read data
// BEHAVIOUR
//  - Clock and reset: one clock (CLOCK); RESET is asynchronous and active-high.
//  - Reset: RESET=1 sets dout_q to 16'h0000 immediately. Memory array and valid bits are untouched.
//  - active = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF, sampled at the rising CLOCK edge.
//  - Write (active & WREN): for each i with MASKWREN[i]=1, mem[ADDRESS][4i+3:4i] <= DATAIN[4i+3:4i].
//    - Sets valid[ADDRESS] <= 1.
//    - MASKWREN=0 writes nothing and leaves valid unchanged.
//    - dout_q holds its previous value.
//  - Read (active & ~WREN): dout_q <= valid[ADDRESS] ? mem[ADDRESS] : 16'h0000.
//    - Data is visible on DATAOUT in the cycle after the edge (latency 1).
//  - Not active: dout_q holds; no memory change.
//  - DATAOUT = (SLEEP | ~POWEROFF) ? 16'h0000 : dout_q. The gating is combinational.
//  - Leaving SLEEP restores the held dout_q.
//  - Power-off: every edge with POWEROFF=0 clears all valid bits and sets dout_q <= 0.
//    - Previously written words then read 0 after power is restored.
//  - Mode priority: POWEROFF low > SLEEP > STANDBY > CHIPSELECT.
//  - Uninitialised words (never written, or wiped by power-off) read 16'h0000; no X propagation.
//  - Read-during-write on the same address is impossible (single port). WREN alone decides the operation.
//  - Address wraps naturally within 14 bits; there are no out-of-range accesses.
//  - Mid-operation reset: a read launched on the edge where RESET asserts yields DATAOUT=0.
//    - A write on that edge still updates memory (array is not reset).
// STRUCTURE
//  - Shared package sb_ice40_pkg: SPRAM_ADDR_W=14, SPRAM_DATA_W=16, SPRAM_NIBBLES=4, MODE_* encodings.
//  - One sub-module: sb_spram_array, a 16384x16 array with nibble write enables and a 16384-bit valid vector.
//  - Top level holds the mode decode, the dout_q register and the output gating.
// TESTING
//  1. Full-word round trip:
//     - Write 0x1234 to addr 0x0005 with MASKWREN=4'hF.
//     - Read addr 0x0005 -> DATAOUT=0x1234 one cycle after the read edge.
//  2. Nibble mask:
//     - Addr 0x0005 holds 0x1234; write 0xABCD with MASKWREN=4'b1010.
//     - Read -> 0xA2C4.
//  3. Modes:
//     - CHIPSELECT=0 or STANDBY=1 during a write of 0xFFFF -> memory unchanged, DATAOUT holds.
//     - SLEEP=1 -> DATAOUT=0; SLEEP=0 -> previous value returns.
//  4. Power-off:
//     - Write 0x55AA to addr 0x3FFF; pulse POWEROFF=0 for 1 cycle; read 0x3FFF -> 0x0000.
//     - Writes during POWEROFF=0 are ignored.
//  5. Reset and uninitialised reads:
//     - Assert RESET between edges -> DATAOUT=0 immediately.
//     - Memory contents survive reset (re-read of 0x0005 returns 0x1234).
//     - Never-written addr 0x0100 reads 0x0000.
//  6. 32-bit pairing:
//     - Two instances with the picorv32 wstrb mapping (hi uses {{2{wstrb[3]}},{2{wstrb[2]}}}).
//     - sb 0x78 to byte 1 of word 0xDEADBEEF -> readback 0xDEAD78EF.

Source files
------------

// File: rtl/sb_ice40_pkg.sv
// sb_ice40_pkg: shared SPRAM geometry and power-mode decode for the iCE40UP RAM models.
package sb_ice40_pkg;
  localparam int SPRAM_ADDR_W = 14;
  localparam int SPRAM_DATA_W = 16;
  localparam int SPRAM_NIBBLES = 4;
  typedef enum logic [2:0] {MODE_OFF, MODE_SLEEP, MODE_STANDBY, MODE_IDLE, MODE_ACTIVE} mode_t;
  function automatic mode_t spram_mode(input logic cs, input logic sb, input logic sl, input logic po);
    return !po ? MODE_OFF : sl ? MODE_SLEEP : sb ? MODE_STANDBY : !cs ? MODE_IDLE : MODE_ACTIVE;
  endfunction
endpackage

// File: rtl/sb_spram256ka_if.sv
// sb_spram256ka_if: SPRAM access and power-control bundle.
interface sb_spram256ka_if;
  import sb_ice40_pkg::*;
  logic [SPRAM_ADDR_W-1:0] address;
  logic [SPRAM_DATA_W-1:0] datain;
  logic [SPRAM_NIBBLES-1:0] maskwren;
  logic wren;
  logic chipselect;
  logic standby;
  logic sleep;
  logic poweroff;
  logic [SPRAM_DATA_W-1:0] dataout;
  modport master(output address, datain, maskwren, wren, chipselect, standby, sleep, poweroff, input dataout);
  modport slave(input address, datain, maskwren, wren, chipselect, standby, sleep, poweroff, output dataout);
endinterface

// File: rtl/sb_spram_array.sv
// sb_spram_array: 16384x16 array with nibble write enables and per-word valid bits.
module sb_spram_array
  import sb_ice40_pkg::*;
(
  input  logic                     clk,
  input  logic                     we,
  input  logic                     clr,
  input  logic [SPRAM_ADDR_W-1:0]  addr,
  input  logic [SPRAM_DATA_W-1:0]  din,
  input  logic [SPRAM_NIBBLES-1:0] mask,
  output logic [SPRAM_DATA_W-1:0]  rdata
);
  logic [SPRAM_DATA_W-1:0] mem [2**SPRAM_ADDR_W];
  logic [2**SPRAM_ADDR_W-1:0] valid;
  logic [SPRAM_DATA_W-1:0] wdata;
  assign rdata = valid[addr] ? mem[addr] : '0;
  // Unmasked nibbles merge from rdata, so a partial write to an invalid word fills zeros.
  always_comb begin
    wdata = rdata;
    for (int i = 0; i < SPRAM_NIBBLES; i++) wdata[4*i+:4] = mask[i] ? din[4*i+:4] : rdata[4*i+:4];
  end
  always_ff @(posedge clk) begin
    if (clr) valid <= '0;
    else if (we && |mask) valid[addr] <= 1'b1;
    if (we && |mask) mem[addr] <= wdata;
  end
endmodule

// File: rtl/sb_spram256ka.sv
// sb_spram256ka: iCE40UP 256-kbit single-port SRAM with standby, sleep and power-off modes.
module sb_spram256ka
  import sb_ice40_pkg::*;
(
  input logic           clk,
  input logic           rst,
  sb_spram256ka_if.slave bus
);
  mode_t mode;
  logic [SPRAM_DATA_W-1:0] rdata, dout_q;
  assign mode = spram_mode(bus.chipselect, bus.standby, bus.sleep, bus.poweroff);
  sb_spram_array u_array (
    .clk,
    .we   (mode == MODE_ACTIVE && bus.wren),
    .clr  (mode == MODE_OFF),
    .addr (bus.address),
    .din  (bus.datain),
    .mask (bus.maskwren),
    .rdata
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) dout_q <= '0;
    else if (mode == MODE_OFF) dout_q <= '0;
    else if (mode == MODE_ACTIVE && !bus.wren) dout_q <= rdata;
  assign bus.dataout = (bus.sleep || !bus.poweroff) ? '0 : dout_q;
endmodule

// File: tb/tb_sb_spram256ka.sv
// tb_sb_spram256ka: directed and randomized checks of the SPRAM model against a word-level reference.
module tb_sb_spram256ka;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [15:0] mem_m [int];
  logic [15:0] dq = 16'h0000;
  sb_spram256ka_if lo ();
  sb_spram256ka_if hi ();
  sb_spram256ka dut_lo (.clk(clk), .rst(rst), .bus(lo));
  sb_spram256ka dut_hi (.clk(clk), .rst(rst), .bus(hi));
  always #5 clk = ~clk;

  function automatic logic [15:0] rd_m(input int a);
    return mem_m.exists(a) ? mem_m[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_out();
    return (lo.sleep || !lo.poweroff) ? 16'h0000 : dq;
  endfunction

  // Reference: applies the access rules to the lo instance at the coming edge, then advances.
  task automatic tick();
    logic act;
    logic [15:0] w;
    int a;
    a = int'(lo.address);
    act = lo.chipselect && !lo.standby && !lo.sleep && lo.poweroff;
    if (!lo.poweroff) begin
      mem_m.delete();
      dq = 16'h0000;
    end else if (act && lo.wren) begin
      if (lo.maskwren != 4'h0) begin
        w = rd_m(a);
        for (int i = 0; i < 4; i++) if (lo.maskwren[i]) w[4*i+:4] = lo.datain[4*i+:4];
        mem_m[a] = w;
      end
    end else if (act) dq = rd_m(a);
    if (rst) dq = 16'h0000;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic wr, input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    lo.chipselect = cs;
    lo.wren = wr;
    lo.address = a;
    lo.datain = d;
    lo.maskwren = m;
  endtask

  task automatic test_reset();
    lo.poweroff = 1'b0;
    tick();
    tick();
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL reset_off got=%h exp=0000", lo.dataout); end
    lo.poweroff = 1'b1;
    #1;
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL reset_dout got=%h exp=0000", lo.dataout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_trip();
    drive(1'b1, 1'b1, 14'h0005, 16'h1234, 4'hF);
    tick();
    checks++;
    if (lo.dataout !== exp_out()) begin errs++; $display("FAIL write_holds got=%h exp=%h", lo.dataout, exp_out()); end
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h1234) begin errs++; $display("FAIL round_trip got=%h exp=1234", lo.dataout); end
  endtask

  task automatic test_nibble_mask();
    drive(1'b1, 1'b1, 14'h0005, 16'hABCD, 4'b1010);
    tick();
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'hA2C4 || lo.dataout !== exp_out()) begin errs++; $display("FAIL nibble_mask got=%h exp=a2c4", lo.dataout); end
    drive(1'b1, 1'b1, 14'h0005, 16'h9999, 4'h0);
    tick();
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'hA2C4) begin errs++; $display("FAIL mask_zero got=%h exp=a2c4", lo.dataout); end
  endtask

  task automatic test_modes();
    drive(1'b0, 1'b1, 14'h0005, 16'hFFFF, 4'hF);
    tick();
    checks++;
    if (lo.dataout !== 16'hA2C4) begin errs++; $display("FAIL cs_off_hold got=%h exp=a2c4", lo.dataout); end
    drive(1'b1, 1'b1, 14'h0005, 16'hFFFF, 4'hF);
    lo.standby = 1'b1;
    tick();
    checks++;
    if (lo.dataout !== 16'hA2C4) begin errs++; $display("FAIL standby_hold got=%h exp=a2c4", lo.dataout); end
    lo.standby = 1'b0;
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'hA2C4 || lo.dataout !== exp_out()) begin errs++; $display("FAIL mode_mem_kept got=%h exp=a2c4", lo.dataout); end
    lo.sleep = 1'b1;
    #1;
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL sleep_gate got=%h exp=0000", lo.dataout); end
    drive(1'b1, 1'b1, 14'h0005, 16'h0000, 4'hF);
    tick();
    lo.sleep = 1'b0;
    drive(1'b0, 1'b0, 14'h0005, 16'h0000, 4'h0);
    #1;
    checks++;
    if (lo.dataout !== 16'hA2C4) begin errs++; $display("FAIL sleep_restore got=%h exp=a2c4", lo.dataout); end
  endtask

  task automatic test_poweroff();
    drive(1'b1, 1'b1, 14'h3FFF, 16'h55AA, 4'hF);
    tick();
    drive(1'b1, 1'b0, 14'h3FFF, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h55AA) begin errs++; $display("FAIL top_addr got=%h exp=55aa", lo.dataout); end
    drive(1'b1, 1'b1, 14'h0005, 16'h1111, 4'hF);
    lo.poweroff = 1'b0;
    #1;
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL off_gate got=%h exp=0000", lo.dataout); end
    tick();
    lo.poweroff = 1'b1;
    drive(1'b1, 1'b0, 14'h3FFF, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL off_wipe got=%h exp=0000", lo.dataout); end
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h0000 || lo.dataout !== exp_out()) begin errs++; $display("FAIL off_write_ignored got=%h exp=0000", lo.dataout); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 14'h0005, 16'h1234, 4'hF);
    tick();
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL async_reset got=%h exp=0000", lo.dataout); end
    drive(1'b1, 1'b1, 14'h0007, 16'h0F0F, 4'hF);
    tick();
    drive(1'b1, 1'b0, 14'h0005, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL read_in_reset got=%h exp=0000", lo.dataout); end
    rst = 1'b0;
    tick();
    checks++;
    if (lo.dataout !== 16'h1234) begin errs++; $display("FAIL mem_survives got=%h exp=1234", lo.dataout); end
    drive(1'b1, 1'b0, 14'h0007, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h0F0F) begin errs++; $display("FAIL write_in_reset got=%h exp=0f0f", lo.dataout); end
    drive(1'b1, 1'b0, 14'h0100, 16'h0000, 4'h0);
    tick();
    checks++;
    if (lo.dataout !== 16'h0000) begin errs++; $display("FAIL uninit got=%h exp=0000", lo.dataout); end
  endtask

  task automatic test_pairing();
    logic [31:0] wd;
    logic [3:0] ws;
    wd = 32'hDEADBEEF;
    ws = 4'hF;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 14'h0040, wd[15:0], {{2{ws[1]}}, {2{ws[0]}}});
      hi.chipselect = 1'b1;
      hi.wren = 1'b1;
      hi.address = 14'h0040;
      hi.datain = wd[31:16];
      hi.maskwren = {{2{ws[3]}}, {2{ws[2]}}};
      tick();
      wd = {4{8'h78}};
      ws = 4'b0010;
    end
    drive(1'b1, 1'b0, 14'h0040, 16'h0000, 4'h0);
    hi.wren = 1'b0;
    tick();
    hi.chipselect = 1'b0;
    checks++;
    if ({hi.dataout, lo.dataout} !== 32'hDEAD78EF) begin errs++; $display("FAIL pair_sb got=%h exp=dead78ef", {hi.dataout, lo.dataout}); end
  endtask

  task automatic test_random();
    logic [13:0] a;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 1) == 1) ? 14'(3'(n) ^ $urandom_range(0, 7)) : 14'(14'h3FF8 + $urandom_range(0, 7));
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, a, 16'($urandom), 4'($urandom));
      lo.standby = $urandom_range(0, 9) == 0;
      lo.sleep = $urandom_range(0, 11) == 0;
      lo.poweroff = $urandom_range(0, 39) != 0;
      tick();
      checks++;
      if (lo.dataout !== exp_out()) begin errs++; $display("FAIL random n=%0d addr=%h got=%h exp=%h", n, a, lo.dataout, exp_out()); end
    end
    lo.standby = 1'b0;
    lo.sleep = 1'b0;
    lo.poweroff = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 14'h0000, 16'h0000, 4'h0);
    lo.standby = 1'b0;
    lo.sleep = 1'b0;
    lo.poweroff = 1'b1;
    hi.chipselect = 1'b0;
    hi.wren = 1'b0;
    hi.address = 14'h0000;
    hi.datain = 16'h0000;
    hi.maskwren = 4'h0;
    hi.standby = 1'b0;
    hi.sleep = 1'b0;
    hi.poweroff = 1'b1;
    #1;
    test_reset();
    test_round_trip();
    test_nibble_mask();
    test_modes();
    test_poweroff();
    test_reset_mid();
    test_pairing();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
